// File: rtl/axi_stream_sink_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_stream_sink_checker_if
// Brief    : valid/ready beat bundle between a stream source and its sink.
// Revision : 1.0 - initial release
// ============================================================================
interface axi_stream_sink_checker_if #(
    parameter int DWIDTH = 8
) ();
    logic              valid;
    logic [DWIDTH-1:0] data;
    logic              ready;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
endinterface
`default_nettype wire

// File: rtl/axi_stream_sink_checker.sv
`default_nettype none
// ============================================================================
// Module   : axi_stream_sink_checker
// Brief    : stream sink with programmable back-pressure and +1 sequence check.
// Revision : 1.0 - initial release
// ============================================================================
module axi_stream_sink_checker #(
    parameter int         DWIDTH    = 8,
    parameter int         CNT_WIDTH = 16,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  wire                      aclk_i,
    input  wire                      aresetn_i,
    axi_stream_sink_checker_if.slave s_axis,
    input  wire                      enable_i,
    input  wire [1:0]                bp_mode_i,
    input  wire                      clear_i,
    output logic [CNT_WIDTH-1:0]     beat_cnt_o,
    output logic [CNT_WIDTH-1:0]     err_cnt_o,
    output logic                     err_o,
    output logic [DWIDTH-1:0]        err_exp_o,
    output logic [DWIDTH-1:0]        err_got_o
);

    localparam logic [0:0]           c_ST_WAIT_REF = 1'b0;
    localparam logic [0:0]           c_ST_CHECK    = 1'b1;
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX     = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE     = CNT_WIDTH'(1);
    localparam logic [DWIDTH-1:0]    c_DATA_ONE    = DWIDTH'(1);

    logic [1:0]           r_rst_sync;
    logic                 w_rst_n;
    logic                 r_ready;
    logic                 r_tgl;
    logic [7:0]           r_lfsr;
    logic                 w_pat;
    logic                 w_xfer;
    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic                 w_count;
    logic                 w_load_ref;
    logic                 w_mismatch;
    logic [DWIDTH-1:0]    r_ref;
    logic [DWIDTH-1:0]    w_ref_inc;
    logic [CNT_WIDTH-1:0] r_beat_cnt;
    logic [CNT_WIDTH-1:0] r_err_cnt;
    logic                 r_err;
    logic [DWIDTH-1:0]    r_err_exp;
    logic [DWIDTH-1:0]    r_err_got;

    // Reset asserts at once, releases two edges later.
    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) r_rst_sync <= 2'b00;
        else            r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    always_comb begin
        w_pat = 1'b0;
        case (bp_mode_i)
            2'b00:   w_pat = 1'b1;
            2'b01:   w_pat = ~r_tgl;
            2'b10:   w_pat = r_lfsr[0];
            default: w_pat = 1'b0;
        endcase
    end

    // Pattern generators free-run and are deliberately untouched by clear_i.
    always_ff @(posedge aclk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_ready <= 1'b0;
            r_tgl   <= 1'b0;
            r_lfsr  <= LFSR_SEED;
        end else begin
            r_ready <= enable_i & w_pat;
            r_tgl   <= ~r_tgl;
            r_lfsr  <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    assign s_axis.ready = r_ready;
    assign w_xfer       = s_axis.valid & r_ready;
    assign w_ref_inc    = r_ref + c_DATA_ONE;

    always_ff @(posedge aclk_i or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= c_ST_WAIT_REF;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear_i)     w_state_nxt = c_ST_WAIT_REF;
        else if (w_xfer) w_state_nxt = c_ST_CHECK;
    end

    // A clear on the transfer edge consumes the beat without counting it.
    always_comb begin
        w_count    = 1'b0;
        w_load_ref = 1'b0;
        w_mismatch = 1'b0;
        if (w_xfer && !clear_i) begin
            w_count    = 1'b1;
            w_load_ref = 1'b1;
            if (r_state == c_ST_CHECK && s_axis.data != w_ref_inc) w_mismatch = 1'b1;
        end
    end

    always_ff @(posedge aclk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_ref      <= '0;
            r_beat_cnt <= '0;
            r_err_cnt  <= '0;
            r_err      <= 1'b0;
            r_err_exp  <= '0;
            r_err_got  <= '0;
        end else if (clear_i) begin
            r_beat_cnt <= '0;
            r_err_cnt  <= '0;
            r_err      <= 1'b0;
            r_err_exp  <= '0;
            r_err_got  <= '0;
        end else begin
            if (w_load_ref) r_ref <= s_axis.data;
            if (w_count && r_beat_cnt != c_CNT_MAX) r_beat_cnt <= r_beat_cnt + c_CNT_ONE;
            if (w_mismatch) begin
                if (r_err_cnt != c_CNT_MAX) r_err_cnt <= r_err_cnt + c_CNT_ONE;
                r_err <= 1'b1;
                if (!r_err) begin
                    r_err_exp <= w_ref_inc;
                    r_err_got <= s_axis.data;
                end
            end
        end
    end

    assign beat_cnt_o = r_beat_cnt;
    assign err_cnt_o  = r_err_cnt;
    assign err_o      = r_err;
    assign err_exp_o  = r_err_exp;
    assign err_got_o  = r_err_got;

endmodule
`default_nettype wire

// File: doc/axi_stream_sink_checker.md
# axi_stream_sink_checker

Terminal consumer for the valid/ready stream chain: accepts beats from the last pipeline stage, generates a programmable back-pressure pattern on its ready output, and checks that consecutive accepted beats increment by exactly one (mod 2^DWIDTH). It exposes beat and error counters and a first-error capture for bench and on-chip self-test use. Sits at the downstream end of any chain of increment stages.

## Interface
- DWIDTH, 8, data width
- CNT_WIDTH, 16, width of beat and error counters
- LFSR_SEED, 8'hA5, reset value of the 8-bit back-pressure LFSR; must be nonzero
- aclk_i  in  1  clock, all logic on rising edge
- aresetn_i  in  1  asynchronous, active-low reset
- valid_i  in  1  upstream beat valid
- data_i  in  DWIDTH  upstream beat data
- ready_o  out  1  back-pressure to upstream; registered
- enable_i  in  1  allow ready_o to assert
- bp_mode_i  in  2  00 always ready, 01 alternate, 10 LFSR random, 11 never ready
- clear_i  in  1  synchronous clear of statistics and check state
- beat_cnt_o  out  CNT_WIDTH  accepted beats, saturating
- err_cnt_o  out  CNT_WIDTH  sequence errors, saturating
- err_o  out  1  sticky, set on first error
- err_exp_o  out  DWIDTH  expected value at first error
- err_got_o  out  DWIDTH  received value at first error

## Operation
- Transfer: valid_i & ready_o on a rising edge. Block never drops or duplicates a beat; upstream holds data while ready_o is low.
- ready_o register: next = enable_i & pat, where pat is:
  - 00: 1.
  - 01: ~tgl. tgl is 1 bit, resets to 0, and toggles every cycle.
  - 10: lfsr[0].
  - 11: 0.
- LFSR: advances every cycle regardless of mode. next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
- Check FSM, two states:
  - WAIT_REF (reset state): on transfer, ref <= data_i, beat_cnt++, go to CHECK. No compare.
  - CHECK: on transfer, beat_cnt++. If data_i != ref+1 (DWIDTH-bit wrap), err_cnt++ and err_o <= 1. If err_o was 0, capture err_exp_o <= ref+1 and err_got_o <= data_i. ref <= data_i unconditionally (resync after error).
- Counters saturate at all-ones and do not wrap.
- clear_i: beat_cnt, err_cnt, err_o, err_exp_o, err_got_o <= 0; FSM -> WAIT_REF. ready_o, tgl and LFSR are unaffected.
- clear_i coincident with a transfer: clear wins. The beat is consumed (handshake completes) but not counted, and the next beat becomes the new reference.

## Timing
- Reset values: ready_o 0, beat_cnt_o 0, err_cnt_o 0, err_o 0, err_exp_o 0, err_got_o 0, lfsr LFSR_SEED, tgl 0, FSM WAIT_REF.
- Reset asserts asynchronously: outputs take reset values immediately, no clock required.
- Reset deasserts synchronously to aclk_i through the usual two-flop release.
- enable_i or bp_mode_i change affects ready_o on the next rising edge (1-cycle latency).
- Statistics outputs are registered and reflect a transfer immediately after the edge on which it occurred.
- ready_o does not depend combinationally on valid_i.
- Reset mid-stream: an in-flight beat is abandoned, ready_o drops at once, and the LFSR sequence restarts from the seed.
- With the default seed, the mode-10 ready sequence after enable is 1, 0, 1 (lfsr A5 -> 4A -> 95).

## Test plan
- Mode 00, enable_i=1, continuous valid with data 0x00..0x09 -> ready_o high from the 2nd edge after enable; beat_cnt_o=10, err_cnt_o=0, err_o=0.
- Mode 01, source holds valid with data 0x10..0x19 -> ready_o alternates 1,0; 10 beats accepted over about 20 cycles; no error; each beat counted once.
- Data 0x05,0x06,0x07,0x09,0x0A -> err_cnt_o=1, err_o=1, err_exp_o=0x08, err_got_o=0x09; 0x0A is accepted without error (resync); beat_cnt_o=5.
- Wrap: data 0xFE,0xFF,0x00,0x01 -> err_cnt_o=0, beat_cnt_o=4.
- clear_i pulsed on the same edge as the transfer of beat 0x33 after prior errors -> all statistics 0; next beat 0x50 is taken as reference with no error.
- Mode 10, aresetn_i pulsed low between edges mid-stream -> ready_o goes to 0 without a clock edge and counters read 0; after release the ready pattern repeats 1,0,1 identically to the first run.
